// File: rtl/axi_arb_pkg.sv
// ============================================================================
//  Module      : axi_arb_pkg
//  Description : Shared types and constants for the AXI4-Lite read-channel
//                arbiter and its round-robin picker.
//                  arb_state_t  - arbiter FSM state (2 bits)
//                  RESP_OKAY    - AXI OKAY response code
//                  RESP_SLVERR  - AXI SLVERR response code
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_arb_pkg;

    // Arbiter transaction state. Encoding is fixed so that state values
    // seen on a debug bus or in a waveform are stable across builds.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : axi_arb_pkg

`default_nettype wire

// File: rtl/axi_read_arbiter_rr_pick2.sv
// ============================================================================
//  Module      : rr_pick2
//  Description : Two-way round-robin picker, purely combinational.
//                A lone request always wins; when both request, the side
//                that was NOT granted last time wins. Shared between the
//                read-side and write-side arbiters.
//  Ports       : req[1:0]   in   request vector, bit N = requester N
//                last       in   index of the previously granted requester
//                gnt_valid  out  at least one request present
//                gnt_idx    out  index of the winning requester
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            // Contention: hand the grant to whoever did not have it last.
            gnt_idx = ~last;
        end else begin
            // Zero or one request: bit 1 decides; idx is don't-care when
            // gnt_valid is low but is kept at a defined value.
            gnt_idx = req[1];
        end
    end

endmodule : rr_pick2

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
// ============================================================================
//  Module      : axi_read_arbiter
//  Description : Shares one AXI4-Lite read channel (AR + R) between two
//                requesters: s0 (instruction fetch) and s1 (data load).
//                One outstanding read at a time, round-robin per
//                transaction. Read data/response are registered and
//                returned only to the granted requester.
//                Transaction flow: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//  Ports       : clk, rst                 clock, async active-high reset
//                sN_axi_ar* (N=0,1)       requester address channel
//                sN_axi_r*                requester read-data channel
//                m_axi_ar*, m_axi_r*      downstream read channel
//                grant_id                 current / last granted requester
//                busy                     high whenever state != IDLE
//                gnt0_cnt, gnt1_cnt,      statistics counters, present only
//                conflict_cnt             when AXI_READ_ARB_STATS_EN is
//                                         defined
//  Build macro : AXI_READ_ARB_STATS_EN - adds the statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    // Requester 0 (instruction fetch)
    input  logic [ADDR_W-1:0] s0_axi_araddr,
    input  logic              s0_axi_arvalid,
    output logic              s0_axi_arready,
    output logic [DATA_W-1:0] s0_axi_rdata,
    output logic [1:0]        s0_axi_rresp,
    output logic              s0_axi_rvalid,
    input  logic              s0_axi_rready,

    // Requester 1 (data load)
    input  logic [ADDR_W-1:0] s1_axi_araddr,
    input  logic              s1_axi_arvalid,
    output logic              s1_axi_arready,
    output logic [DATA_W-1:0] s1_axi_rdata,
    output logic [1:0]        s1_axi_rresp,
    output logic              s1_axi_rvalid,
    input  logic              s1_axi_rready,

    // Downstream (mmu core-side read port)
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,

    // Status
    output logic              grant_id,
    output logic              busy
`ifdef AXI_READ_ARB_STATS_EN
    ,
    output logic [31:0]       gnt0_cnt,
    output logic [31:0]       gnt1_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    arb_state_t        r_state;
    arb_state_t        w_next_state;

    logic              r_last_grant;
    logic              r_grant_id;

    logic [ADDR_W-1:0] r_m_araddr;
    logic              r_m_arvalid;
    logic              r_m_rready;

    logic [1:0]        r_s_rvalid;
    logic [DATA_W-1:0] r_s_rdata [0:1];
    logic [1:0]        r_s_rresp [0:1];

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic              w_ar_hs;
    logic [ADDR_W-1:0] w_sel_araddr;
    logic              w_m_r_hs;
    logic              w_s_rready_sel;
    logic              w_s_r_hs;

    rr_pick2 u_pick (
        .req       ({s1_axi_arvalid, s0_axi_arvalid}),
        .last      (r_last_grant),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // The requester-side AR handshake completes in the same IDLE cycle in
    // which the grant is decided, so arready is purely combinational.
    assign w_ar_hs        = (r_state == IDLE) && w_gnt_valid;
    assign s0_axi_arready = w_ar_hs && !w_gnt_idx;
    assign s1_axi_arready = w_ar_hs &&  w_gnt_idx;

    assign w_sel_araddr   = w_gnt_idx ? s1_axi_araddr : s0_axi_araddr;

    assign w_m_r_hs       = (r_state == DATA) && m_axi_rvalid && r_m_rready;

    // Only the granted requester's rready can close the transaction.
    assign w_s_rready_sel = r_grant_id ? s1_axi_rready : s0_axi_rready;
    assign w_s_r_hs       = (r_state == RESP) && w_s_rready_sel;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid)   w_next_state = ADDR;
            ADDR:    if (m_axi_arready) w_next_state = DATA;
            DATA:    if (w_m_r_hs)      w_next_state = RESP;
            RESP:    if (w_s_r_hs)      w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered handshake outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant  <= 1'b1;
            r_grant_id    <= 1'b0;
            r_m_araddr    <= '0;
            r_m_arvalid   <= 1'b0;
            r_m_rready    <= 1'b0;
            r_s_rvalid    <= 2'b00;
            r_s_rdata[0]  <= '0;
            r_s_rdata[1]  <= '0;
            r_s_rresp[0]  <= RESP_OKAY;
            r_s_rresp[1]  <= RESP_OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_m_araddr  <= w_sel_araddr;
                        r_m_arvalid <= 1'b1;
                        r_grant_id  <= w_gnt_idx;
                    end
                end
                ADDR: begin
                    // Address stays frozen until the downstream takes it;
                    // afterwards it returns to zero so an idle bus is quiet.
                    if (m_axi_arready) begin
                        r_m_arvalid <= 1'b0;
                        r_m_araddr  <= '0;
                        r_m_rready  <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_m_r_hs) begin
                        r_m_rready             <= 1'b0;
                        r_s_rdata[r_grant_id]  <= m_axi_rdata;
                        r_s_rresp[r_grant_id]  <= m_axi_rresp;
                        r_s_rvalid[r_grant_id] <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_s_r_hs) begin
                        r_s_rvalid    <= 2'b00;
                        r_s_rdata[0]  <= '0;
                        r_s_rdata[1]  <= '0;
                        r_s_rresp[0]  <= RESP_OKAY;
                        r_s_rresp[1]  <= RESP_OKAY;
                        // Fairness pointer moves only when the transaction
                        // fully retires, so an abandoned read does not count.
                        r_last_grant  <= r_grant_id;
                    end
                end
                default: begin
                    r_m_arvalid <= 1'b0;
                    r_m_rready  <= 1'b0;
                    r_s_rvalid  <= 2'b00;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign m_axi_araddr  = r_m_araddr;
    assign m_axi_arvalid = r_m_arvalid;
    assign m_axi_rready  = r_m_rready;

    assign s0_axi_rvalid = r_s_rvalid[0];
    assign s0_axi_rdata  = r_s_rdata[0];
    assign s0_axi_rresp  = r_s_rresp[0];

    assign s1_axi_rvalid = r_s_rvalid[1];
    assign s1_axi_rdata  = r_s_rdata[1];
    assign s1_axi_rresp  = r_s_rresp[1];

    assign grant_id      = r_grant_id;
    assign busy          = (r_state != IDLE);

`ifdef AXI_READ_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics: observation only, never feeds back into arbitration.
    // ------------------------------------------------------------------------
    logic [31:0] r_gnt0_cnt;
    logic [31:0] r_gnt1_cnt;
    logic [31:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = (r_state == IDLE) && s0_axi_arvalid && s1_axi_arvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0_cnt     <= 32'd0;
            r_gnt1_cnt     <= 32'd0;
            r_conflict_cnt <= 32'd0;
        end else begin
            if (s0_axi_arready) r_gnt0_cnt     <= r_gnt0_cnt + 32'd1;
            if (s1_axi_arready) r_gnt1_cnt     <= r_gnt1_cnt + 32'd1;
            if (w_conflict)     r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign gnt0_cnt     = r_gnt0_cnt;
    assign gnt1_cnt     = r_gnt1_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule : axi_read_arbiter

`default_nettype wire
